i2c_byte_master: RTL and testbench
==================================

Name: i2c_byte_master

Overview:
- Avalon-MM slave I2C master that sequences the SCL/SDA open-drain pads at the byte level: START, 8-bit write with ACK sample, 8-bit read with ACK/NACK drive, and STOP.
- Replaces software bit-banging through the SDA/SCL PIO ports.
- Sits on the Nios system bus; the top level converts `scl_oe`/`sda_oe` to open-drain pads.

Parameters:
- `CLK_DIV`, 125: clk cycles per quarter SCL period (50 MHz / (4 × 125) = 100 kHz). Legal range 2..65535.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 2: register select. 0 = DATA, 1 = CMD/STATUS, 2–3 reserved.
- `chipselect` in 1: Avalon chip select.
- `write_n` in 1: Avalon write strobe, active low.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `scl_oe` out 1: 1 = pull SCL low, 0 = release.
- `sda_oe` out 1: 1 = pull SDA low, 0 = release.
- `scl_in` in 1: SCL pad level, synchronised externally.
- `sda_in` in 1: SDA pad level, synchronised externally.

Behaviour:
- **Bus access:**
  - Write = `chipselect & ~write_n`.
  - `readdata` is registered every cycle, so it is valid the cycle after `address` is presented. Read has no side effects.
  - Reserved addresses read 0; writes to them are ignored.
- **DATA (addr 0):**
  - Write: `tx_byte <= writedata[7:0]`. Ignored while busy.
  - Read: `{24'b0, rx_byte}`.
- **CMD (addr 1) write fields:**
  - [0] START, [1] STOP, [2] WRITE, [3] READ, [4] NACK (1 = send NACK after READ).
  - Accepted only when idle and at least one of [3:0] is set; otherwise ignored.
  - WRITE and READ both set: WRITE is executed, READ is dropped.
  - On accept: `busy` is 1 from the next cycle, `done` clears, and the command fields are latched.
- **STATUS (addr 1) read:**
  - [0] `busy`.
  - [1] `rx_ack`: SDA sampled in the 9th bit of the last WRITE; 0 = ACK.
  - [2] `done`: sticky, set when a command completes, cleared by the next accepted command.
- **Sequence:** the phases START → (WRITE | READ) → STOP execute in order; phases whose flags are clear are skipped. After the last phase: `busy` = 0 and `done` = 1 on the same cycle.
- **Quarter timing:**
  - Each phase is a run of quarters of `CLK_DIV` cycles, counted by a down counter.
  - During any quarter with SCL released, the counter holds while `scl_in` = 0 (clock stretching).
- **FSM states:** IDLE, START, BIT, STOP. Quarter index q0–q3.
- **START:**
  - q0: release SDA and SCL.
  - q1: SDA low.
  - q2: SCL low.
  - q3: hold.
  - Works as a repeated start because the previous phase leaves SCL low.
- **BIT** (9 bits, bit counter 8→0, MSB first, bit 0 = ACK slot):
  - q0: SCL low; SDA set to the bit value.
  - q1: SCL released.
  - q2: SCL released; `sda_in` sampled on the last cycle of q2.
  - q3: SCL low.
- **WRITE data:**
  - Data bits: `sda_oe = ~tx_bit`.
  - ACK slot: SDA released; the sample goes to `rx_ack`.
- **READ data:**
  - Data bits: SDA released; samples shift into `rx_byte`, which is written on completion.
  - ACK slot: `sda_oe = ~NACK`.
- **STOP:**
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2: SDA released.
  - q3: idle hold.
- **Durations** (no stretching): START = 4·CLK_DIV, byte = 36·CLK_DIV, STOP = 4·CLK_DIV cycles.
- **Reset**, including mid-operation, takes effect on the next clk edge:
  - `scl_oe` = `sda_oe` = 0.
  - FSM = IDLE.
  - `busy` = `done` = `rx_ack` = 0.
  - `tx_byte` = `rx_byte` = 0.
  - `readdata` = 0.
  - Counters cleared.
- **Idle state:** after reset with no command, both lines stay released.
- **Driving:** the block never drives SDA while the slave owns it (read data bits, write ACK slot).

Test Plan:
1. **Write byte:** CLK_DIV=4; DATA=0xA5; CMD=0x7 (START|WRITE|STOP); slave model ACKs → SDA bits 1,0,1,0,0,1,0,1 at SCL rising edges; `rx_ack`=0; `busy` high exactly 176 cycles; STATUS=0x4.
2. **Read with NACK:** CMD=0x1A (READ|STOP|NACK); slave returns 0x3C → DATA reads 0x3C; `sda_oe`=0 during the ACK slot; STOP present; STATUS=0x4.
3. **Write with NACK from slave:** CMD=0x4 with the slave model leaving SDA high in the ACK slot → `rx_ack`=1; no STOP generated; SCL left low.
4. **Clock stretching:** slave holds `scl_in` low 20 cycles in bit 3's q1 → `busy` extends by 20 cycles; bit values are unchanged.
5. **Busy protection:** during a transfer, write DATA=0xFF and CMD=0x8 → both ignored; `tx_byte` keeps the original value; a CMD of 0x0 written while idle is also ignored (`busy` stays 0).
6. **Reset mid-byte:** assert `reset` one cycle during bit 5 → next cycle `scl_oe`=`sda_oe`=0, STATUS=0, DATA=0; a following CMD=0x1 executes normally.

Source files
------------

// File: rtl/i2c_byte_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_byte_master                                                    |
// | Avalon-MM I2C master: START, byte write/read with ACK, STOP.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module i2c_byte_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in
);
  localparam logic [1:0]  c_IDLE   = 2'd0;
  localparam logic [1:0]  c_START  = 2'd1;
  localparam logic [1:0]  c_BIT    = 2'd2;
  localparam logic [1:0]  c_STOP   = 2'd3;
  localparam logic [15:0] c_RELOAD = 16'(CLK_DIV - 1);

  logic [1:0]  r_state, r_q;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit;
  logic [7:0]  r_tx, r_rx, r_shift;
  logic        r_done, r_rx_ack, r_stop, r_write, r_read, r_nack;
  logic        r_scl_hold, r_sda_hold;
  logic [31:0] r_readdata;

  logic        w_wr, w_busy, w_accept, w_stall, w_bit_sda, w_scl, w_sda, w_unused;
  logic [2:0]  w_idx;

  assign w_wr     = chipselect & ~write_n;
  assign w_busy   = (r_state != c_IDLE);
  assign w_accept = w_wr && (address == 2'd1) && !w_busy && (writedata[3:0] != 4'd0);
  assign w_idx    = 3'(r_bit - 4'd1);
  assign w_unused = &{1'b0, writedata[31:8]};

  // SDA pull for the current bit: data MSB first, bit counter 0 is the ACK slot.
  always_comb begin
    w_bit_sda = 1'b0;
    if (r_write) w_bit_sda = (r_bit != 4'd0) ? ~r_tx[w_idx] : 1'b0;
    else if (r_read) w_bit_sda = (r_bit == 4'd0) ? ~r_nack : 1'b0;
  end

  // Lines keep their last driven level while idle (e.g. SCL low after a STOP-less byte).
  always_comb begin
    w_scl = r_scl_hold;
    w_sda = r_sda_hold;
    case (r_state)
      c_START: begin w_scl = r_q[1];                           w_sda = (r_q != 2'd0); end
      c_BIT:   begin w_scl = (r_q == 2'd0) || (r_q == 2'd3);   w_sda = w_bit_sda;     end
      c_STOP:  begin w_scl = (r_q == 2'd0);                    w_sda = !r_q[1];       end
      default: begin end
    endcase
  end

  assign w_stall  = w_busy && !w_scl && !scl_in;
  assign scl_oe   = w_scl;
  assign sda_oe   = w_sda;
  assign readdata = r_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_q        <= 2'd0;
      r_cnt      <= 16'd0;
      r_bit      <= 4'd0;
      r_tx       <= 8'd0;
      r_rx       <= 8'd0;
      r_shift    <= 8'd0;
      r_done     <= 1'b0;
      r_rx_ack   <= 1'b0;
      r_stop     <= 1'b0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_nack     <= 1'b0;
      r_scl_hold <= 1'b0;
      r_sda_hold <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      case (address)
        2'd0:    r_readdata <= {24'd0, r_rx};
        2'd1:    r_readdata <= {29'd0, r_done, r_rx_ack, w_busy};
        default: r_readdata <= 32'd0;
      endcase

      if (w_busy) begin
        r_scl_hold <= w_scl;
        r_sda_hold <= w_sda;
      end

      if (w_wr && (address == 2'd0) && !w_busy) r_tx <= writedata[7:0];

      if (w_accept) begin
        r_stop  <= writedata[1];
        r_write <= writedata[2];
        r_read  <= writedata[3] & ~writedata[2];
        r_nack  <= writedata[4];
        r_done  <= 1'b0;
        r_q     <= 2'd0;
        r_cnt   <= c_RELOAD;
        r_bit   <= 4'd8;
        if (writedata[0])                     r_state <= c_START;
        else if (writedata[2] | writedata[3]) r_state <= c_BIT;
        else                                  r_state <= c_STOP;
      end else if (w_busy && !w_stall) begin
        if (r_cnt != 16'd0) begin
          r_cnt <= r_cnt - 16'd1;
        end else begin
          r_cnt <= c_RELOAD;
          r_q   <= r_q + 2'd1;
          if (r_state == c_BIT && r_q == 2'd2) begin
            if (r_bit == 4'd0 && r_write) r_rx_ack <= sda_in;
            if (r_bit != 4'd0 && r_read)  r_shift  <= {r_shift[6:0], sda_in};
          end
          if (r_q == 2'd3) begin
            case (r_state)
              c_START: begin
                if (r_write | r_read) begin
                  r_state <= c_BIT;
                  r_bit   <= 4'd8;
                end else if (r_stop) begin
                  r_state <= c_STOP;
                end else begin
                  r_state <= c_IDLE;
                  r_done  <= 1'b1;
                end
              end
              c_BIT: begin
                if (r_bit != 4'd0) begin
                  r_bit <= r_bit - 4'd1;
                end else begin
                  if (r_read) r_rx <= r_shift;
                  if (r_stop) begin
                    r_state <= c_STOP;
                  end else begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b1;
                  end
                end
              end
              default: begin
                r_state <= c_IDLE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2c_byte_master                                                 |
// | Self-checking bench with an I2C slave model and bit scoreboard.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_byte_master;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        scl_oe, sda_oe, scl_in, sda_in;
  logic        stretch = 1'b0;
  logic        pull = 1'b0;

  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & ~pull;

  i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .scl_in     (scl_in),
    .sda_in     (sda_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model state; expected {sda line, sda_oe} per SCL rise live in exp_q.
  logic [1:0] exp_q[$];
  bit         armed = 1'b0, seen_fall = 1'b0, rd_mode = 1'b0, sack = 1'b0;
  bit         stretch_en = 1'b0, prev_oe = 1'b0, scl_prev = 1'b1;
  logic [7:0] sbyte = 8'd0;
  int         rise_cnt = 0;
  int         stretch_cnt = 0;

  function automatic logic slave_pull(input int idx);
    if (idx >= 9) return 1'b0;
    if (rd_mode)  return (idx < 8) ? ~sbyte[7-idx] : 1'b0;
    return (idx == 8) ? sack : 1'b0;
  endfunction

  always @(negedge clk) begin : mon
    logic       line;
    logic [1:0] e;
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) stretch = 1'b0;
    end else if (stretch_en && prev_oe && !scl_oe && rise_cnt == 3) begin
      stretch     = 1'b1;
      stretch_cnt = 20;
      stretch_en  = 1'b0;
    end
    prev_oe = scl_oe;
    line = ~scl_oe & ~stretch;
    if (armed && line != scl_prev) begin
      if (!line) begin
        if (seen_fall) pull = slave_pull(rise_cnt);
        seen_fall = 1'b1;
      end else if (seen_fall) begin
        if (rise_cnt < 9) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bit%0d: unexpected SCL rise, got a bit expected none", rise_cnt);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("bit%0d sda/oe", rise_cnt), {30'd0, sda_in, sda_oe}, {30'd0, e});
          end
        end
        rise_cnt++;
      end
    end
    scl_prev = line;
  end

  task automatic arm(input bit rd, input logic [7:0] tx, input logic [7:0] sb,
                     input bit ack, input bit nack, input bit str);
    exp_q.delete();
    rd_mode    = rd;
    sbyte      = sb;
    sack       = ack;
    stretch_en = str;
    rise_cnt   = 0;
    seen_fall  = 1'b0;
    scl_prev   = ~scl_oe & ~stretch;
    pull       = slave_pull(0);
    if (rd) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({sb[i], 1'b0});
      exp_q.push_back({nack, ~nack});
    end else begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({tx[i], ~tx[i]});
      exp_q.push_back({~ack, 1'b0});
    end
    armed = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
    address = 2'd1;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (readdata[0]) cyc++;
      else if (cyc > 0 && readdata[2]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] tx;
    logic [7:0] sb;
    bit         ack;
    bit         str;
    logic [2:0] exp_status;
    int         exp_busy;
    logic [7:0] exp_rx;
    bit         exp_scl;
    bit         exp_sda;
    int         exp_rises;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] d;
  int          cyc;
  bit          ok;

  initial begin
    // write A5 with ACK; read 3C with NACK; write without STOP, slave NACK; stretched write
    vecs[0] = '{8'h07, 8'hA5, 8'h00, 1'b1, 1'b0, 3'h4, 176, 8'h00, 1'b0, 1'b0, 10};
    vecs[1] = '{8'h1A, 8'hA5, 8'h3C, 1'b1, 1'b0, 3'h4, 160, 8'h3C, 1'b0, 1'b0, 10};
    vecs[2] = '{8'h04, 8'h5A, 8'h00, 1'b0, 1'b0, 3'h6, 144, 8'h3C, 1'b1, 1'b0, 9};
    vecs[3] = '{8'h07, 8'hC3, 8'h00, 1'b1, 1'b1, 3'h4, 196, 8'h3C, 1'b0, 1'b0, 10};

    repeat (3) @(negedge clk);
    check("reset readdata", readdata, 32'd0);
    check("reset scl_oe", {31'd0, scl_oe}, 32'd0);
    check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle scl_oe", {31'd0, scl_oe}, 32'd0);
    check("idle sda_oe", {31'd0, sda_oe}, 32'd0);
    bus_write(2'd2, 32'hFF);
    bus_read(2'd2, d);
    check("reserved read", d, 32'd0);
    bus_read(2'd1, d);
    check("idle status", d, 32'd0);

    for (int v = 0; v < 4; v++) begin
      bus_write(2'd0, {24'd0, vecs[v].tx});
      arm(vecs[v].cmd[3] & ~vecs[v].cmd[2], vecs[v].tx, vecs[v].sb,
          vecs[v].ack, vecs[v].cmd[4], vecs[v].str);
      bus_write(2'd1, {24'd0, vecs[v].cmd});
      wait_done(3000, cyc, ok);
      check($sformatf("v%0d done", v), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d busy cycles", v), cyc, vecs[v].exp_busy);
      check($sformatf("v%0d scl_oe after", v), {31'd0, scl_oe}, {31'd0, vecs[v].exp_scl});
      check($sformatf("v%0d sda_oe after", v), {31'd0, sda_oe}, {31'd0, vecs[v].exp_sda});
      check($sformatf("v%0d scl rises", v), rise_cnt, vecs[v].exp_rises);
      check($sformatf("v%0d bits left", v), exp_q.size(), 32'd0);
      bus_read(2'd1, d);
      check($sformatf("v%0d status", v), d, {29'd0, vecs[v].exp_status});
      bus_read(2'd0, d);
      check($sformatf("v%0d data", v), d, {24'd0, vecs[v].exp_rx});
    end

    // Writes during a transfer are ignored; a zero CMD while idle is ignored.
    bus_write(2'd0, 32'h81);
    arm(1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
    bus_write(2'd1, 32'h7);
    repeat (40) @(negedge clk);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'h8);
    wait_done(3000, cyc, ok);
    check("busy-prot done", {31'd0, ok}, 32'd1);
    check("busy-prot bits left", exp_q.size(), 32'd0);
    repeat (10) @(negedge clk);
    bus_read(2'd1, d);
    check("busy-prot no queued cmd", d, 32'h4);
    arm(1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
    bus_write(2'd1, 32'h7);
    wait_done(3000, cyc, ok);
    check("tx kept done", {31'd0, ok}, 32'd1);
    check("tx kept busy cycles", cyc, 176);
    check("tx kept bits left", exp_q.size(), 32'd0);
    bus_write(2'd1, 32'h0);
    repeat (3) @(negedge clk);
    bus_read(2'd1, d);
    check("zero cmd ignored", d, 32'h4);

    // Reset asserted for one cycle while bit 5 holds SCL and SDA low.
    bus_write(2'd0, 32'h5A);
    arm(1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);
    bus_write(2'd1, 32'h7);
    for (int i = 0; i < 2000; i++) begin
      if (rise_cnt == 6 && scl_oe) break;
      @(negedge clk);
    end
    check("pre-reset scl_oe", {31'd0, scl_oe}, 32'd1);
    check("pre-reset sda_oe", {31'd0, sda_oe}, 32'd1);
    armed = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-reset scl_oe", {31'd0, scl_oe}, 32'd0);
    check("mid-reset sda_oe", {31'd0, sda_oe}, 32'd0);
    check("mid-reset readdata", readdata, 32'd0);
    bus_read(2'd1, d);
    check("mid-reset status", d, 32'd0);
    bus_read(2'd0, d);
    check("mid-reset data", d, 32'd0);
    arm(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    bus_write(2'd1, 32'h1);
    wait_done(1000, cyc, ok);
    check("start-only done", {31'd0, ok}, 32'd1);
    check("start-only busy cycles", cyc, 16);
    check("start-only scl_oe", {31'd0, scl_oe}, 32'd1);
    check("start-only sda_oe", {31'd0, sda_oe}, 32'd1);
    check("start-only rises", rise_cnt, 0);
    bus_read(2'd1, d);
    check("start-only status", d, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
